// File: rtl/rom_pkg.sv
// Shared constants and types for the rom_sync_read block: default geometry,
// the built-in 16-word constant table and the stored-word type.
package rom_pkg;

    localparam int ROM_DATA_W = 16;
    localparam int ROM_ADDR_W = 4;
    localparam int ROM_DEPTH  = 1 << ROM_ADDR_W;

    typedef logic [ROM_DATA_W-1:0] rom_word_t;

    // Built-in table used when no init file is supplied.
    localparam rom_word_t DEFAULT_ROM [0:ROM_DEPTH-1] = '{
        16'h0103, 16'h5200, 16'he0b9, 16'h0412,
        16'h4839, 16'h0112, 16'h0377, 16'h0572,
        16'hcafe, 16'h6225, 16'h1447, 16'haeec,
        16'h52dd, 16'h1113, 16'h4444, 16'h5555
    };

endpackage

// File: rtl/rom_out_stage.sv
// One output register stage for the ROM read path. Clears to zero on a
// synchronous active-high reset, otherwise captures its input every edge.
module rom_out_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] dout_r;

    // Capture the incoming word each edge; reset discards it and forces zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r <= {W{1'b0}};
        end else begin
            dout_r <= din;
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/rom_sync_read.sv
// rom_sync_read: 16-word x 16-bit ROM with registered synchronous read.
// The storage array M stays a plain writable reg array so test benches can
// patch words by hierarchical reference; reset never touches it.
// Optional feature macro: ROM_OUT_REG_EN adds a second output register
// stage after the array read (read latency 2 instead of 1).
module rom_sync_read
    import rom_pkg::*;
#(
    parameter int    DATA_W    = ROM_DATA_W,
    parameter int    ADDR_W    = ROM_ADDR_W,
    parameter string INIT_FILE = ""
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] ADR,
    output logic [DATA_W-1:0] D
);

    localparam int DEPTH = 1 << ADDR_W;

    reg   [DATA_W-1:0] M [0:DEPTH-1];

    logic [DATA_W-1:0] rd_word_s;
    logic [DATA_W-1:0] stage0_s;

    // Power-up contents: the built-in table (repeated if the array is deeper
    // than the table).
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            M[i] = DATA_W'(DEFAULT_ROM[i % ROM_DEPTH]);
        end
    end

    // Array read mux; the full address range is populated, so no bounds logic.
    always_comb begin
        rd_word_s = M[ADR];
    end

    rom_out_stage #(.W(DATA_W)) u_stage0 (
        .clk  (CLK),
        .rst  (RST),
        .din  (rd_word_s),
        .dout (stage0_s)
    );

`ifdef ROM_OUT_REG_EN
    logic [DATA_W-1:0] stage1_s;

    rom_out_stage #(.W(DATA_W)) u_stage1 (
        .clk  (CLK),
        .rst  (RST),
        .din  (stage0_s),
        .dout (stage1_s)
    );

    assign D = stage1_s;
`else
    assign D = stage0_s;
`endif

endmodule

// File: tb/tb_rom_sync_read.sv
// Directed, table-driven bench for rom_sync_read. Expected words are the
// hand-copied default table; the pipeline depth follows ROM_OUT_REG_EN.
module tb_rom_sync_read;

`ifdef ROM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        CLK;
    logic        RST;
    logic [3:0]  ADR;
    logic [15:0] D;

    int n_vec;
    int n_err;

    rom_sync_read dut (
        .CLK (CLK),
        .RST (RST),
        .ADR (ADR),
        .D   (D)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One record per clock: inputs applied, then the latency-1 expectation.
    typedef struct {
        logic        rst;
        logic [3:0]  adr;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: D=%h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic void add(input logic r, input logic [3:0] a, input logic [15:0] e, input string nm);
        vec_t v;
        v.rst  = r;
        v.adr  = a;
        v.exp  = e;
        v.name = nm;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [15:0] tbl [0:15];
        logic [15:0] prev_exp;
        logic [15:0] exp_now;
        logic [15:0] held;
        n_vec = 0;
        n_err = 0;

        tbl = '{16'h0103, 16'h5200, 16'he0b9, 16'h0412,
                16'h4839, 16'h0112, 16'h0377, 16'h0572,
                16'hcafe, 16'h6225, 16'h1447, 16'haeec,
                16'h52dd, 16'h1113, 16'h4444, 16'h5555};

        // Reset rows: any address, output must be zero.
        add(1'b1, 4'd8,  16'h0000, "reset0");
        add(1'b1, 4'd15, 16'h0000, "reset1");
        // Full address sweep.
        for (int i = 0; i < 16; i++) begin
            add(1'b0, 4'(i), tbl[i], $sformatf("sweep%0d", i));
        end
        // Back-to-back wrap between the end words.
        add(1'b0, 4'd15, 16'h5555, "wrap15a");
        add(1'b0, 4'd0,  16'h0103, "wrap0a");
        add(1'b0, 4'd15, 16'h5555, "wrap15b");
        add(1'b0, 4'd0,  16'h0103, "wrap0b");

        RST = 1'b1;
        ADR = 4'd0;
        #2;

        prev_exp = 16'h0000;
        foreach (vecs[k]) begin
            RST = vecs[k].rst;
            ADR = vecs[k].adr;
            step();
            if (LAT == 1) begin
                exp_now = vecs[k].exp;
            end else begin
                exp_now = vecs[k].rst ? 16'h0000 : prev_exp;
            end
            prev_exp = vecs[k].exp;
            check(vecs[k].name, D, exp_now);
        end

        // Output must hold between edges even when the address changes.
        held = D;
        ADR  = 4'd8;
        #3;
        check("hold_between_edges", D, held);

        // Bench override of a word becomes visible on the next read.
        dut.M[2] = 16'h1234;
        ADR = 4'd2;
        for (int k = 0; k < LAT; k++) step();
        check("override_m2", D, 16'h1234);
        ADR = 4'd3;
        for (int k = 0; k < LAT; k++) step();
        check("neighbour_m3", D, 16'h0412);

        // Reset in the middle of a read stream.
        ADR = 4'd8;
        for (int k = 0; k < LAT; k++) step();
        check("pre_reset_read", D, 16'hcafe);
        RST = 1'b1;
        step();
        check("midreset_zero", D, 16'h0000);
        RST = 1'b0;
        step();
        if (LAT == 2) begin
            check("post_reset_first_edge", D, 16'h0000);
            step();
        end
        check("post_reset_read", D, 16'hcafe);

        // Reset never alters the array contents.
        ADR = 4'd2;
        for (int k = 0; k < LAT; k++) step();
        check("m2_survives_reset", D, 16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
